conv3x3_mac: RTL and testbench

- Downstream consumer of the 3x3 patch latch in the conv datapath.
- Takes nine signed 8-bit patch pixels and nine signed 8-bit kernel weights, plus a signed bias.
- Performs one multiply-accumulate per cycle, then rounds, right-shifts (requantises) and saturates to a signed 8-bit feature-map output.
- Feeds the output-feature-map write stage through a single-cycle valid pulse.

---
 rtl/conv3x3_mac.sv | 131 +++++++++++++
 tb/tb_conv3x3_mac.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_mac.sv
// 3x3 signed MAC: nine serial multiply-accumulates onto a bias, then round, requantise and saturate to int8.
// Optional build macro CONV3X3_MAC_RELU_EN clamps negative results to zero.
module conv3x3_mac #(
    parameter int unsigned SHIFT  = 7,
    parameter int unsigned BIAS_W = 16,
    parameter int unsigned ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [71:0]       pixels,
    input  logic [71:0]       weights,
    input  logic [BIAS_W-1:0] bias,
    output logic              busy,
    output logic [7:0]        result,
    output logic              result_valid
);

    localparam int unsigned TAPS_W = 72;
    localparam int unsigned IDX_W  = 4;
    localparam logic signed [ACC_W-1:0] RND    = ACC_W'((1 << SHIFT) >> 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

    typedef enum logic [1:0] {IDLE, MAC, POST} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [TAPS_W-1:0]        pix_q, pix_d;
    logic [TAPS_W-1:0]        wgt_q, wgt_d;
    logic                     busy_q, busy_d;
    logic [7:0]               result_q, result_d;
    logic                     valid_q, valid_d;

    logic signed [BIAS_W-1:0] bias_s;
    logic signed [7:0]        pix_k, wgt_k;
    logic signed [15:0]       prod_c;
    logic signed [ACC_W-1:0]  rnd_c, shr_c;
    logic [7:0]               sat_c;

    assign bias_s = bias;
    assign pix_k  = pix_q[8*idx_q +: 8];
    assign wgt_k  = wgt_q[8*idx_q +: 8];
    assign prod_c = pix_k * wgt_k;

    // Round half up, arithmetic shift, clamp to int8 (optionally ReLU)
    always_comb begin
        rnd_c = acc_q + RND;
        shr_c = rnd_c >>> SHIFT;
        if (shr_c > SAT_HI) begin
            sat_c = 8'sd127;
        end else if (shr_c < SAT_LO) begin
            sat_c = 8'h80;
        end else begin
            sat_c = shr_c[7:0];
        end
`ifdef CONV3X3_MAC_RELU_EN
        if (sat_c[7]) begin
            sat_c = 8'd0;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        pix_d    = pix_q;
        wgt_d    = wgt_q;
        busy_d   = busy_q;
        result_d = result_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pix_d   = pixels;
                    wgt_d   = weights;
                    acc_d   = ACC_W'(bias_s);
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod_c);
                idx_d = IDX_W'(idx_q + IDX_W'(1));
                if (idx_q == IDX_W'(8)) begin
                    state_d = POST;
                end
            end
            POST: begin
                result_d = sat_c;
                valid_d  = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            pix_q    <= '0;
            wgt_q    <= '0;
            busy_q   <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            pix_q    <= pix_d;
            wgt_q    <= wgt_d;
            busy_q   <= busy_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_conv3x3_mac.sv
// Directed plus random checks of conv3x3_mac (SHIFT=0 and SHIFT=7 instances) against an arithmetic model.
module tb_conv3x3_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        st0 = 1'b0;
    logic        st7 = 1'b0;
    logic [71:0] pixels = '0;
    logic [71:0] weights = '0;
    logic [15:0] bias = '0;
    logic        busy0, busy7, valid0, valid7;
    logic [7:0]  result0, result7;

    int errors = 0;
    int checks = 0;
    int p[9];
    int w[9];

    always #5 clk = ~clk;

    conv3x3_mac #(.SHIFT(0), .BIAS_W(16), .ACC_W(24)) dut0 (
        .clk(clk), .rst(rst), .start(st0), .pixels(pixels), .weights(weights),
        .bias(bias), .busy(busy0), .result(result0), .result_valid(valid0));

    conv3x3_mac #(.SHIFT(7), .BIAS_W(16), .ACC_W(24)) dut7 (
        .clk(clk), .rst(rst), .start(st7), .pixels(pixels), .weights(weights),
        .bias(bias), .busy(busy7), .result(result7), .result_valid(valid7));

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Dot product plus bias, round half up, shift, clamp, optional ReLU
    function automatic int model(input int sh, input int b);
        int acc = b;
        for (int k = 0; k < 9; k++) acc += p[k] * w[k];
        if (sh > 0) acc += (1 << (sh - 1));
        acc = acc >>> sh;
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
`ifdef CONV3X3_MAC_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc;
    endfunction

    function automatic logic signed [31:0] obs_res(input bit sel);
        return sel ? 32'($signed(result7)) : 32'($signed(result0));
    endfunction
    function automatic logic signed [31:0] obs_busy(input bit sel);
        return sel ? 32'(busy7) : 32'(busy0);
    endfunction
    function automatic logic signed [31:0] obs_valid(input bit sel);
        return sel ? 32'(valid7) : 32'(valid0);
    endfunction

    task automatic drive_ops(input int b);
        for (int k = 0; k < 9; k++) begin
            pixels[8*k +: 8]  = 8'(p[k]);
            weights[8*k +: 8] = 8'(w[k]);
        end
        bias = 16'(b);
    endtask

    task automatic set_all(input int pv, input int wv);
        for (int k = 0; k < 9; k++) begin
            p[k] = pv;
            w[k] = wv;
        end
    endtask

    // One full transaction: latency, busy window, single valid pulse, value and hold
    task automatic run_op(input bit sel, input string tag, input int b);
        int exp;
        exp = model(sel ? 7 : 0, b);
        @(negedge clk);
        drive_ops(b);
        if (sel) st7 = 1'b1; else st0 = 1'b1;
        @(posedge clk); #1;
        st0 = 1'b0;
        st7 = 1'b0;
        pixels  = {$urandom(), $urandom(), 8'($urandom())};
        weights = {$urandom(), $urandom(), 8'($urandom())};
        bias    = 16'($urandom());
        chk({tag, "_busy_t0"}, obs_busy(sel), 1);
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            if (e < 10) begin
                chk({tag, "_busy_mid"}, obs_busy(sel), 1);
                chk({tag, "_valid_early"}, obs_valid(sel), 0);
            end else begin
                chk({tag, "_valid_t10"}, obs_valid(sel), 1);
                chk({tag, "_busy_t10"}, obs_busy(sel), 0);
                chk({tag, "_result"}, obs_res(sel), exp);
            end
        end
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, obs_valid(sel), 0);
        chk({tag, "_result_hold"}, obs_res(sel), exp);
    endtask

    initial begin
        int exp;
        int nvalid;

        // Reset state
        #3;
        chk("rst_busy7", 32'(busy7), 0);
        chk("rst_result7", 32'($signed(result7)), 0);
        chk("rst_valid7", 32'(valid7), 0);
        chk("rst_result0", 32'($signed(result0)), 0);
        @(negedge clk);
        rst = 1'b1;

        set_all(1, 1);
        run_op(1'b0, "basic", 0);

        set_all(0, 0);
        run_op(1'b0, "bias_pos", 100);
        run_op(1'b0, "bias_neg", -300);

        set_all(127, 127);
        run_op(1'b1, "pos_sat", 0);
        set_all(-128, 127);
        run_op(1'b1, "neg_sat", 0);

        set_all(0, 0);
        p[0] = 3;  w[0] = 64;
        run_op(1'b1, "round_pos", 0);
        p[0] = -3; w[0] = 64;
        run_op(1'b1, "round_neg", 0);

        // Restarts at T3 and T10 are ignored; restart at T11 is accepted
        set_all(50, 20);
        exp = model(7, 0);
        @(negedge clk);
        drive_ops(0);
        st7 = 1'b1;
        @(posedge clk); #1;
        st7 = 1'b0;
        for (int e = 1; e <= 22; e++) begin
            @(negedge clk);
            st7 = (e == 3 || e == 10 || e == 11);
            @(posedge clk); #1;
            chk("hs_valid", 32'(valid7), (e == 10 || e == 21) ? 1 : 0);
            if (e == 10 || e == 21) chk("hs_result", 32'($signed(result7)), exp);
            if (e == 12) chk("hs_restart_busy", 32'(busy7), 1);
        end
        st7 = 1'b0;
        chk("hs_idle_busy", 32'(busy7), 0);

        // Leave a nonzero result, then abort a run with reset at T5
        set_all(127, 127);
        run_op(1'b1, "pre_abort", 0);
        @(negedge clk);
        drive_ops(0);
        st7 = 1'b1;
        @(posedge clk); #1;
        st7 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy7), 0);
        chk("abort_result", 32'($signed(result7)), 0);
        chk("abort_valid", 32'(valid7), 0);
        @(negedge clk);
        rst = 1'b1;
        nvalid = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (valid7 !== 1'b0) nvalid++;
        end
        chk("abort_no_valid", nvalid, 0);
        chk("abort_result_held", 32'($signed(result7)), 0);

        // Random transactions on both instances
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < 9; k++) begin
                p[k] = int'($urandom_range(0, 255)) - 128;
                w[k] = int'($urandom_range(0, 255)) - 128;
            end
            if (i % 2 == 0) begin
                run_op(1'b1, "rand7", int'($urandom_range(0, 65535)) - 32768);
            end else begin
                for (int k = 0; k < 9; k++) w[k] = int'($urandom_range(0, 6)) - 3;
                p[int'($urandom_range(0, 8))] = 0;
                run_op(1'b0, "rand0", int'($urandom_range(0, 400)) - 200);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
